ps2_frame_decoder: RTL and testbench

//   Consumes 11-bit PS/2 frames from the keyboard shift-register stage (PS/2-clock domain).

---
 rtl/ps2_frame_decoder_pkg.sv | 42 ++++
 rtl/ps2_frame_decoder_sync_bit.sv | 27 ++
 rtl/ps2_frame_decoder.sv | 143 ++++++++++++++
 tb/tb_ps2_frame_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_frame_decoder_pkg.sv
// ps2_pkg: shared definitions for the PS/2 frame decoder.
//   - ps2State_e     : decoder prefix state (IDLE, EXT, BRK, EXT_BRK)
//   - PS2_PREFIX_*   : E0 (extended) and F0 (break) prefix bytes
//   - PS2_*_IDX      : bit positions inside an 11-bit PS/2 frame
//   - ps2DataByte()  : extracts the data byte (frame carries LSB first)
//   - ps2FrameOk()   : start/parity/stop validation
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2State_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int PS2_START_IDX    = 10;
    localparam int PS2_DATA_MSB_IDX = 9;
    localparam int PS2_DATA_LSB_IDX = 2;
    localparam int PS2_PARITY_IDX   = 1;
    localparam int PS2_STOP_IDX     = 0;

    // Data bit i sits at frame[9-i]: the highest data index holds bit 0.
    function automatic logic [7:0] ps2DataByte(input logic [10:0] frame);
        logic [7:0] dataByte;
        dataByte = '0;
        for (int i = 0; i <= PS2_DATA_MSB_IDX - PS2_DATA_LSB_IDX; i++) begin
            dataByte[i] = frame[PS2_DATA_MSB_IDX - i];
        end
        return dataByte;
    endfunction

    // Data plus parity must carry an odd number of ones.
    function automatic logic ps2FrameOk(input logic [10:0] frame);
        return (frame[PS2_START_IDX] == 1'b0) &&
               (frame[PS2_STOP_IDX] == 1'b1) &&
               (^frame[PS2_DATA_MSB_IDX:PS2_PARITY_IDX] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_frame_decoder_sync_bit.sv
// sync_bit: N-flop synchronizer for a single level signal.
//   clk    in  system clock
//   reset  in  asynchronous, active-high; clears every stage
//   d_i    in  asynchronous level
//   q_o    out synchronized level, N clk cycles later
module sync_bit #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] stages_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages_q <= '0;
        end else begin
            stages_q <= {stages_q[N-2:0], d_i};
        end
    end

    assign q_o = stages_q[N-1];

endmodule

// File: rtl/ps2_frame_decoder.sv
// ps2_frame_decoder: turns 11-bit PS/2 frames into key events in the clk domain.
//   clk            in   system clock
//   reset          in   asynchronous, active-high
//   frame_i        in   frame from the PS/2 shift register, stable while frame_full_i=1
//   frame_full_i   in   PS/2-domain flag, high while a complete frame is held
//   scancode_o     out  last emitted scancode (prefixes stripped), holds between events
//   key_valid_o    out  1-cycle pulse when a new key event is presented
//   key_release_o  out  1 = break (F0 seen), 0 = make
//   key_extended_o out  1 = E0 prefix seen
//   frame_error_o  out  1-cycle pulse on bad start, parity or stop bit
module ps2_frame_decoder
    import ps2_pkg::*;
#(
    parameter int FRAME_W        = 11,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               frame_full_i,
    output logic [7:0]         scancode_o,
    output logic               key_valid_o,
    output logic               key_release_o,
    output logic               key_extended_o,
    output logic               frame_error_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic               fullSync;
    logic               fullPrev_q;
    logic               captureValid_q;
    logic [FRAME_W-1:0] captureFrame_q;

    ps2State_e          state_q, state_d;
    logic [CNT_W-1:0]   timeoutCnt_q, timeoutCnt_d;
    logic [7:0]         scancode_q, scancode_d;
    logic               keyRelease_q, keyRelease_d;
    logic               keyExtended_q, keyExtended_d;
    logic               keyValid_q, keyValid_d;
    logic               frameError_q, frameError_d;

    logic [7:0]         capByte;
    logic               capOk;

    sync_bit #(.N(SYNC_STAGES)) uFullSync (
        .clk   (clk),
        .reset (reset),
        .d_i   (frame_full_i),
        .q_o   (fullSync)
    );

    // Edge register resets to 0, so a flag already high at reset release
    // is treated as a fresh frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fullPrev_q     <= 1'b0;
            captureValid_q <= 1'b0;
            captureFrame_q <= '0;
        end else begin
            fullPrev_q     <= fullSync;
            captureValid_q <= fullSync & ~fullPrev_q;
            if (fullSync & ~fullPrev_q) begin
                captureFrame_q <= frame_i;
            end
        end
    end

    assign capByte = ps2DataByte(captureFrame_q);
    assign capOk   = ps2FrameOk(captureFrame_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            timeoutCnt_q  <= '0;
            scancode_q    <= '0;
            keyRelease_q  <= 1'b0;
            keyExtended_q <= 1'b0;
            keyValid_q    <= 1'b0;
            frameError_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timeoutCnt_q  <= timeoutCnt_d;
            scancode_q    <= scancode_d;
            keyRelease_q  <= keyRelease_d;
            keyExtended_q <= keyExtended_d;
            keyValid_q    <= keyValid_d;
            frameError_q  <= frameError_d;
        end
    end

    // A capture is checked before the timeout, so a frame arriving on the
    // expiry cycle is still decoded with the pending prefix.
    always_comb begin
        state_d       = state_q;
        timeoutCnt_d  = timeoutCnt_q;
        scancode_d    = scancode_q;
        keyRelease_d  = keyRelease_q;
        keyExtended_d = keyExtended_q;
        keyValid_d    = 1'b0;
        frameError_d  = 1'b0;

        if (captureValid_q) begin
            timeoutCnt_d = '0;
            if (!capOk) begin
                frameError_d = 1'b1;
                state_d      = IDLE;
            end else if (capByte == PS2_PREFIX_EXT) begin
                state_d = EXT;
            end else if (capByte == PS2_PREFIX_BRK) begin
                unique case (state_q)
                    IDLE:    state_d = BRK;
                    EXT:     state_d = EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else begin
                keyValid_d    = 1'b1;
                scancode_d    = capByte;
                keyRelease_d  = (state_q == BRK) || (state_q == EXT_BRK);
                keyExtended_d = (state_q == EXT) || (state_q == EXT_BRK);
                state_d       = IDLE;
            end
        end else if (state_q != IDLE) begin
            if (timeoutCnt_q == CNT_LAST) begin
                state_d      = IDLE;
                timeoutCnt_d = '0;
            end else begin
                timeoutCnt_d = timeoutCnt_q + 1'b1;
            end
        end else begin
            timeoutCnt_d = '0;
        end
    end

    assign scancode_o     = scancode_q;
    assign key_valid_o    = keyValid_q;
    assign key_release_o  = keyRelease_q;
    assign key_extended_o = keyExtended_q;
    assign frame_error_o  = frameError_q;

endmodule

// File: tb/tb_ps2_frame_decoder.sv
// Testbench for ps2_frame_decoder: table-driven directed frames, hand-written
// timeout/reset/long-pulse sequences, and randomized frames checked against
// a prefix-flag reference model.
module tb_ps2_frame_decoder;

    localparam int T = 64;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } event_t;

    typedef struct {
        logic [10:0] f;
        int          hi;
        int          lo;
        event_t      exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] frame;
    logic        frameFull;
    logic [7:0]  scancode;
    logic        keyValid;
    logic        keyRelease;
    logic        keyExtended;
    logic        frameError;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lastRise = 0;

    event_t obsQ[$];

    bit         prefE;
    bit         prefF;
    logic [7:0] hCode;
    logic       hRel;
    logic       hExt;

    always #5 clk = ~clk;

    ps2_frame_decoder #(
        .FRAME_W        (11),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_i        (frame),
        .frame_full_i   (frameFull),
        .scancode_o     (scancode),
        .key_valid_o    (keyValid),
        .key_release_o  (keyRelease),
        .key_extended_o (keyExtended),
        .frame_error_o  (frameError)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        event_t ev;
        if (!reset && (keyValid || frameError)) begin
            ev.kind = keyValid ? 1 : 2;
            ev.code = scancode;
            ev.rel  = keyRelease;
            ev.ext  = keyExtended;
            obsQ.push_back(ev);
            vectors++;
            if (keyValid && frameError) begin
                miscompares++;
                $display("[TB] FAIL pulse_exclusive: key_valid=%b frame_error=%b, required not both high",
                         keyValid, frameError);
            end
        end
    end

    function automatic event_t mkEv(input int kind, input logic [7:0] code, input logic rel, input logic ext);
        event_t ev;
        ev.kind = kind;
        ev.code = code;
        ev.rel  = rel;
        ev.ext  = ext;
        return ev;
    endfunction

    function automatic logic [10:0] mkFrame(input logic [7:0] b);
        logic [10:0] f;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) f[9 - i] = b[i];
        f[1] = ~^b;
        f[0] = 1'b1;
        return f;
    endfunction

    // Reference model: two prefix flags; a gap between frames longer than T
    // cycles drops any pending prefix.
    function automatic event_t modelFrame(input logic [10:0] f, input int gap);
        event_t     ev;
        logic [7:0] b;
        int         ones;
        ev = mkEv(0, 8'h00, 1'b0, 1'b0);
        if (gap > T) begin
            prefE = 0;
            prefF = 0;
        end
        for (int i = 0; i < 8; i++) b[i] = f[9 - i];
        ones = $countones(f[9:1]);
        if (f[10] !== 1'b0 || f[0] !== 1'b1 || (ones % 2) == 0) begin
            ev.kind = 2;
            prefE = 0;
            prefF = 0;
        end else if (b == 8'hE0) begin
            prefE = 1;
            prefF = 0;
        end else if (b == 8'hF0) begin
            prefF = 1;
        end else begin
            ev = mkEv(1, b, prefF, prefE);
            hCode = b;
            hRel  = prefF;
            hExt  = prefE;
            prefE = 0;
            prefF = 0;
        end
        return ev;
    endfunction

    task automatic modelReset();
        prefE = 0;
        prefF = 0;
        hCode = 8'h00;
        hRel  = 1'b0;
        hExt  = 1'b0;
        obsQ.delete();
    endtask

    task automatic applyStimulus(input logic [10:0] f, input int hi, input int lo, output event_t modelEv);
        int gap;
        @(posedge clk);
        #1;
        gap = cyc - lastRise;
        lastRise = cyc;
        frame = f;
        frameFull = 1'b1;
        modelEv = modelFrame(f, gap);
        repeat (hi) @(posedge clk);
        #1;
        frameFull = 1'b0;
        frame = 11'($urandom);
        repeat (lo - 1) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input event_t exp);
        event_t got;
        int     n;
        n = obsQ.size();
        got = (n > 0) ? obsQ[0] : mkEv(0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (exp.kind == 0) begin
            if (n != 0) begin
                miscompares++;
                $display("[TB] FAIL %s event: got %0d pulses (first kind=%0d code=%h), required none",
                         name, n, got.kind, got.code);
            end
        end else if (n != 1 || got.kind != exp.kind ||
                     (exp.kind == 1 && (got.code !== exp.code || got.rel !== exp.rel || got.ext !== exp.ext))) begin
            miscompares++;
            $display("[TB] FAIL %s event: got n=%0d kind=%0d code=%h rel=%b ext=%b, required n=1 kind=%0d code=%h rel=%b ext=%b",
                     name, n, got.kind, got.code, got.rel, got.ext, exp.kind, exp.code, exp.rel, exp.ext);
        end
        obsQ.delete();
        vectors++;
        if ({scancode, keyRelease, keyExtended} !== {hCode, hRel, hExt}) begin
            miscompares++;
            $display("[TB] FAIL %s hold: got code=%h rel=%b ext=%b, required code=%h rel=%b ext=%b",
                     name, scancode, keyRelease, keyExtended, hCode, hRel, hExt);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        vectors++;
        if ({scancode, keyValid, keyRelease, keyExtended, frameError} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL %s: got code=%h valid=%b rel=%b ext=%b err=%b, required all 0",
                     name, scancode, keyValid, keyRelease, keyExtended, frameError);
        end
    endtask

    task automatic doReset(input string name);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkResetOutputs(name);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        event_t      mEv;
        logic [10:0] f;
        int          r;
        logic [7:0]  b;

        reset = 1'b1;
        frame = 11'h000;
        frameFull = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        v.hi = 4;
        v.lo = 6;
        v.f = 11'h0E1;          v.exp = mkEv(1, 8'h1C, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'hF0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'h1C);   v.exp = mkEv(1, 8'h1C, 1'b1, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'hE0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'hF0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'h75);   v.exp = mkEv(1, 8'h75, 1'b1, 1'b1); vecs.push_back(v);
        v.f = 11'h0E3;          v.exp = mkEv(2, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = 11'h4E1;          v.exp = mkEv(2, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = 11'h0E0;          v.exp = mkEv(2, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'hE0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = 11'h0E3;          v.exp = mkEv(2, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'h1C);   v.exp = mkEv(1, 8'h1C, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'hE0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'hF0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'hE0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'h1C);   v.exp = mkEv(1, 8'h1C, 1'b0, 1'b1); vecs.push_back(v);
        v.f = mkFrame(8'hF0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'hF0);   v.exp = mkEv(0, 8'h00, 1'b0, 1'b0); vecs.push_back(v);
        v.f = mkFrame(8'h5A);   v.exp = mkEv(1, 8'h5A, 1'b1, 1'b0); vecs.push_back(v);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].f, vecs[i].hi, vecs[i].lo, mEv);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Prefix expires when the next frame is more than T cycles away.
        applyStimulus(mkFrame(8'hE0), 4, T + 10 - 4, mEv);
        checkOutput("timeout_long_e0", mkEv(0, 8'h00, 1'b0, 1'b0));
        applyStimulus(mkFrame(8'h1C), 4, 6, mEv);
        checkOutput("timeout_long_key", mkEv(1, 8'h1C, 1'b0, 1'b0));

        applyStimulus(mkFrame(8'hE0), 4, T - 10 - 4, mEv);
        checkOutput("timeout_short_e0", mkEv(0, 8'h00, 1'b0, 1'b0));
        applyStimulus(mkFrame(8'h1C), 4, 6, mEv);
        checkOutput("timeout_short_key", mkEv(1, 8'h1C, 1'b0, 1'b1));

        // Capture landing on the expiry cycle keeps the prefix; one cycle later it is gone.
        applyStimulus(mkFrame(8'hE0), 4, T - 4, mEv);
        checkOutput("timeout_edge_e0", mkEv(0, 8'h00, 1'b0, 1'b0));
        applyStimulus(mkFrame(8'h6B), 4, 6, mEv);
        checkOutput("timeout_edge_key", mkEv(1, 8'h6B, 1'b0, 1'b1));

        applyStimulus(mkFrame(8'hE0), 4, T + 1 - 4, mEv);
        checkOutput("timeout_past_e0", mkEv(0, 8'h00, 1'b0, 1'b0));
        applyStimulus(mkFrame(8'h6B), 4, 6, mEv);
        checkOutput("timeout_past_key", mkEv(1, 8'h6B, 1'b0, 1'b0));

        applyStimulus(mkFrame(8'h1C), 200, 6, mEv);
        checkOutput("held_high", mkEv(1, 8'h1C, 1'b0, 1'b0));

        applyStimulus(mkFrame(8'hE0), 4, 6, mEv);
        checkOutput("rst_prefix_e0", mkEv(0, 8'h00, 1'b0, 1'b0));
        doReset("rst_prefix_outputs");
        applyStimulus(mkFrame(8'h1C), 4, 6, mEv);
        checkOutput("rst_prefix_key", mkEv(1, 8'h1C, 1'b0, 1'b0));

        // Flag already high while reset is released counts as a new frame.
        @(posedge clk);
        #1;
        reset = 1'b1;
        f = mkFrame(8'h1C);
        frame = f;
        frameFull = 1'b1;
        @(negedge clk);
        checkResetOutputs("rst_full_outputs");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        mEv = modelFrame(f, 0);
        lastRise = cyc;
        repeat (8) @(posedge clk);
        #1;
        frameFull = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("rst_full_key", mkEv(1, 8'h1C, 1'b0, 1'b0));

        for (int i = 0; i < 40; i++) begin
            int hi;
            int lo;
            r = $urandom_range(0, 99);
            if (r < 25) begin
                f = mkFrame(8'hE0);
            end else if (r < 45) begin
                f = mkFrame(8'hF0);
            end else if (r < 55) begin
                f = mkFrame(8'($urandom));
                case ($urandom_range(0, 2))
                    0:       f[10] = ~f[10];
                    1:       f[1]  = ~f[1];
                    default: f[0]  = ~f[0];
                endcase
            end else begin
                b = 8'($urandom);
                while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom);
                f = mkFrame(b);
            end
            hi = $urandom_range(4, 8);
            lo = $urandom_range(4, T + 16 - hi);
            applyStimulus(f, hi, lo, mEv);
            checkOutput($sformatf("rand%0d", i), mEv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
